// File: rtl/matrix_power_gen_if.sv
// Request/result bundle between the matrix-power generator and whoever drives it.
// The master issues start/poly/steps; the slave returns busy/done and the eight matrix rows.
interface matrix_power_gen_if #(
  parameter int STEP_W = 8
);
  logic              start;
  logic [7:0]        poly;
  logic [STEP_W-1:0] steps;
  logic              busy;
  logic              done;
  logic [7:0]        matrix_row_0;
  logic [7:0]        matrix_row_1;
  logic [7:0]        matrix_row_2;
  logic [7:0]        matrix_row_3;
  logic [7:0]        matrix_row_4;
  logic [7:0]        matrix_row_5;
  logic [7:0]        matrix_row_6;
  logic [7:0]        matrix_row_7;

  modport master (
    output start, poly, steps,
    input  busy, done,
    input  matrix_row_0, matrix_row_1, matrix_row_2, matrix_row_3,
    input  matrix_row_4, matrix_row_5, matrix_row_6, matrix_row_7
  );

  modport slave (
    input  start, poly, steps,
    output busy, done,
    output matrix_row_0, matrix_row_1, matrix_row_2, matrix_row_3,
    output matrix_row_4, matrix_row_5, matrix_row_6, matrix_row_7
  );
endinterface

// File: rtl/matrix_power_gen.sv
// Computes M^K over GF(2) for an 8-bit Galois LFSR by square-and-multiply, one row per clock.
// Optional macro MATRIX_POW_EARLY_EXIT_EN: stop squaring once no higher bits of K remain.
module matrix_power_gen #(
  parameter int STEP_W = 8
) (
  input logic              clock,
  input logic              reset,
  matrix_power_gen_if.slave bus
);

  localparam int BIT_W = (STEP_W > 1) ? $clog2(STEP_W) : 1;
  localparam logic [7:0][7:0] IDENT = 64'h8040201008040201;
`ifdef MATRIX_POW_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MUL, SQR, FIN} state_e;

  state_e            state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [STEP_W-1:0] k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0][7:0]   r_q, r_d;
  logic [7:0][7:0]   p_q, p_d;
  logic [7:0][7:0]   t_q, t_d;
  logic [7:0][7:0]   out_q, out_d;

  logic [7:0] mul_row;
  logic [7:0] sq_row;
  logic       upper_zero;

  // One row of A*B: XOR of the B rows selected by the set bits of A's row.
  function automatic logic [7:0] row_mul(input logic [7:0] a_row, input logic [7:0][7:0] b);
    logic [7:0] acc;
    acc = '0;
    for (int j = 0; j < 8; j++) begin
      if (a_row[j]) acc = acc ^ b[j];
    end
    return acc;
  endfunction

  function automatic logic [7:0][7:0] base_m(input logic [7:0] poly);
    logic [7:0][7:0] m;
    m[0] = poly;
    for (int i = 1; i < 8; i++) m[i] = 8'h01 << (i - 1);
    return m;
  endfunction

  assign mul_row    = row_mul(r_q[row_q], p_q);
  assign sq_row     = row_mul(p_q[row_q], p_q);
  assign upper_zero = ((k_q >> bit_q) >> 1) == '0;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    bit_d   = bit_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    p_d     = p_q;
    t_d     = t_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_d     = bus.steps;
          r_d     = IDENT;
          p_d     = base_m(bus.poly);
          bit_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
          state_d = (EARLY_EXIT && bus.steps == '0) ? SQR : MUL;
        end
      end
      MUL: begin
        // Rows are rewritten in place: each new row needs only its own old row and P.
        if (k_q[bit_q]) r_d[row_q] = mul_row;
        row_d = row_q + 3'd1;
        if (row_q == 3'd7) state_d = SQR;
      end
      SQR: begin
        if (EARLY_EXIT && row_q == 3'd0 && upper_zero) begin
          state_d = FIN;
        end else begin
          t_d[row_q] = sq_row;
          row_d      = row_q + 3'd1;
          if (row_q == 3'd7) begin
            // P is still needed by every row, so it is replaced only once all rows exist.
            p_d[7]   = sq_row;
            p_d[6:0] = t_q[6:0];
            bit_d    = bit_q + 1'b1;
            state_d  = (bit_q == BIT_W'(STEP_W - 1)) ? FIN : MUL;
          end
        end
      end
      FIN: begin
        out_d   = r_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      bit_q   <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= IDENT;
      p_q     <= IDENT;
      t_q     <= IDENT;
      out_q   <= IDENT;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bit_q   <= bit_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      p_q     <= p_d;
      t_q     <= t_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.matrix_row_0 = out_q[0];
  assign bus.matrix_row_1 = out_q[1];
  assign bus.matrix_row_2 = out_q[2];
  assign bus.matrix_row_3 = out_q[3];
  assign bus.matrix_row_4 = out_q[4];
  assign bus.matrix_row_5 = out_q[5];
  assign bus.matrix_row_6 = out_q[6];
  assign bus.matrix_row_7 = out_q[7];

endmodule

// File: tb/tb_matrix_power_gen.sv
// Bench for matrix_power_gen: vector table, hand sequences and random runs against an LFSR-stepping model.
module tb_matrix_power_gen;

  localparam int STEP_W = 8;
  localparam logic [63:0] IDENT = 64'h8040201008040201;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  matrix_power_gen_if #(.STEP_W(STEP_W)) bus ();

  matrix_power_gen #(.STEP_W(STEP_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  poly;
    logic [7:0]  steps;
    logic [63:0] exp_rows;
  } vec_t;

  vec_t vecs[4];

  // Reference: row i of M^K is the state reached from 1<<i after K single LFSR steps.
  function automatic logic [7:0] step_n(input logic [7:0] s, input logic [7:0] poly, input int k);
    logic [7:0] x;
    x = s;
    for (int n = 0; n < k; n++) x = (x >> 1) ^ (x[0] ? poly : 8'h00);
    return x;
  endfunction

  function automatic logic [63:0] model_rows(input logic [7:0] poly, input int k);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = step_n(8'h01 << i, poly, k);
    return r;
  endfunction

  function automatic logic [7:0] apply_rows(input logic [63:0] rows, input logic [7:0] s);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) if (s[i]) acc = acc ^ rows[i*8 +: 8];
    return acc;
  endfunction

  function automatic int exp_lat(input logic [7:0] k);
`ifdef MATRIX_POW_EARLY_EXIT_EN
    int m;
    if (k == 8'h00) return 2;
    m = 0;
    for (int b = 0; b < 8; b++) if (k[b]) m = b;
    return 16 * m + 10;
`else
    return 16 * STEP_W + 1;
`endif
  endfunction

  function automatic logic [63:0] rows_now();
    return {bus.matrix_row_7, bus.matrix_row_6, bus.matrix_row_5, bus.matrix_row_4,
            bus.matrix_row_3, bus.matrix_row_2, bus.matrix_row_1, bus.matrix_row_0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present a request; the following rising edge (e0) samples it.
  task automatic kick(input logic [7:0] p, input logic [7:0] k);
    bus.poly  = p;
    bus.steps = k;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done, starting from edge count n0; bounded.
  task automatic wait_done(input int n0, input int lat, input string tag);
    int n;
    int bad_busy;
    int changed;
    logic [63:0] snap;
    n = n0;
    bad_busy = 0;
    changed = 0;
    snap = rows_now();
    while (!bus.done && n < 700) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.done) begin
        if (!bus.busy) bad_busy++;
        if (rows_now() !== snap) changed++;
      end
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_busy_during"}, 64'(bad_busy), 64'd0);
    check({tag, "_rows_hold"}, 64'(changed), 64'd0);
    check({tag, "_busy_low_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [7:0] rp;
    logic [7:0] rk;
    logic [7:0] rs;
    int seen_done;
    n_pass = 0;
    n_total = 0;

    vecs[0] = '{poly: 8'hB8, steps: 8'd1, exp_rows: 64'h40201008040201B8};
    vecs[1] = '{poly: 8'h00, steps: 8'd3, exp_rows: 64'h1008040201000000};
    vecs[2] = '{poly: 8'h00, steps: 8'd8, exp_rows: 64'h0000000000000000};
    vecs[3] = '{poly: 8'hB8, steps: 8'd0, exp_rows: IDENT};

    bus.start = 1'b0;
    bus.poly  = 8'h00;
    bus.steps = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_rows", rows_now(), IDENT);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) begin
      kick(vecs[v].poly, vecs[v].steps);
      check("busy_after_e0", 64'(bus.busy), 64'd1);
      wait_done(0, exp_lat(vecs[v].steps), "vec");
      check("vec_rows", rows_now(), vecs[v].exp_rows);
      @(posedge clk);
      #1;
      check("done_width", 64'(bus.done), 64'd0);
      check("rows_after_done", rows_now(), vecs[v].exp_rows);
    end

    // Eight-step matrix, then use it as the downstream stage would with seed 01.
    kick(8'hB8, 8'd8);
    wait_done(0, exp_lat(8'd8), "k8");
    check("k8_rows", rows_now(), model_rows(8'hB8, 8));
    check("k8_downstream_seed01", 64'(apply_rows(rows_now(), 8'h01)), 64'(step_n(8'h01, 8'hB8, 8)));

    // A second start while busy must be ignored.
    kick(8'hB8, 8'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.poly  = 8'h00;
    bus.steps = 8'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(5, exp_lat(8'd1), "repulse");
    check("repulse_rows", rows_now(), 64'h40201008040201B8);

    // Start presented while done is high is accepted on that edge.
    kick(8'h1D, 8'd3);
    check("chain_busy", 64'(bus.busy), 64'd1);
    wait_done(0, exp_lat(8'd3), "chain");
    check("chain_rows", rows_now(), model_rows(8'h1D, 3));

    // Asynchronous reset in the middle of a run.
    @(posedge clk);
    #1;
    kick(8'hB8, 8'hFF);
    repeat (39) begin
      @(posedge clk);
      #1;
    end
    #3;
    rst = 1'b1;
    #1;
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_done", 64'(bus.done), 64'd0);
    check("midreset_rows", rows_now(), IDENT);
    seen_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done++;
    end
    check("midreset_no_done", 64'(seen_done), 64'd0);
    kick(8'h5A, 8'd5);
    wait_done(0, exp_lat(8'd5), "after_reset");
    check("after_reset_rows", rows_now(), model_rows(8'h5A, 5));

    // Random polynomials, step counts and downstream states.
    for (int r = 0; r < 10; r++) begin
      rp = 8'($urandom);
      rk = 8'($urandom_range(0, 255));
      rs = 8'($urandom);
      @(posedge clk);
      #1;
      kick(rp, rk);
      wait_done(0, exp_lat(rk), "rand");
      check("rand_rows", rows_now(), model_rows(rp, int'(rk)));
      check("rand_apply", 64'(apply_rows(rows_now(), rs)), 64'(step_n(rs, rp, int'(rk))));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
